// File: rtl/otp_auth_ctrl.sv
// ============================================================================
// Module   : otp_auth_ctrl
// Purpose  : OTP capture, user-code compare, grant/deny status and timed lockout.
//            Optional button debounce filter enabled by defining OTP_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module otp_auth_ctrl #(
  parameter int CODE_W      = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1024,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [CODE_W-1:0]                 otp_in,
  input  logic [CODE_W-1:0]                 user_in,
  input  logic                              otp_latch,
  input  logic                              user_latch,
  output logic                              armed,
  output logic                              grant,
  output logic                              deny,
  output logic                              locked,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt,
  output logic [CODE_W-1:0]                 otp_q
);

  localparam int c_FW = $clog2(MAX_FAIL + 1);
  localparam int c_TW = $clog2(LOCK_CYCLES);
  localparam logic [c_TW-1:0] c_LOCK_LOAD  = c_TW'(LOCK_CYCLES - 1);
  localparam logic [c_FW-1:0] c_MAX_FAIL   = c_FW'(MAX_FAIL);
  localparam logic [c_FW:0]   c_FAIL_LIMIT = (c_FW + 1)'(MAX_FAIL);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_CHECK = 3'd2,
    ST_GRANT = 3'd3,
    ST_DENY  = 3'd4,
    ST_LOCK  = 3'd5
  } state_t;

  // Reset: asserts asynchronously, releases two clocks after the pin deasserts
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // Button conditioning: bit 0 = otp_latch, bit 1 = user_latch
  logic [1:0] w_btn_raw;
  logic [1:0] w_edge;

  assign w_btn_raw = {user_latch, otp_latch};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_level;
    logic                   r_level_d;
    logic                   r_pulse;

    always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) r_sync <= '0;
      else          r_sync <= {r_sync[SYNC_STAGES-2:0], w_btn_raw[b]};
    end

`ifdef OTP_DEBOUNCE_EN
    localparam int c_DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    logic [c_DW-1:0] r_db_cnt;
    logic            r_db_level;

    // Filtered level follows only after DB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
        r_db_cnt   <= '0;
        r_db_level <= 1'b0;
      end else if (r_sync[SYNC_STAGES-1] == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_DW'(DB_CYCLES - 1)) begin
        r_db_level <= r_sync[SYNC_STAGES-1];
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end

    assign w_level = r_db_level;
`else
    assign w_level = r_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
        r_level_d <= 1'b0;
        r_pulse   <= 1'b0;
      end else begin
        r_level_d <= w_level;
        r_pulse   <= w_level & ~r_level_d;
      end
    end

    assign w_edge[b] = r_pulse;
  end

  // Control FSM
  state_t            r_state, w_state_nxt;
  logic [CODE_W-1:0] r_otp_q, w_otp_nxt;
  logic [CODE_W-1:0] r_user_q, w_user_nxt;
  logic [c_FW-1:0]   r_fail_cnt, w_fail_nxt;
  logic [c_TW-1:0]   r_timer, w_timer_nxt;
  logic              r_armed, w_armed_nxt;
  logic              r_grant, w_grant_nxt;
  logic              r_deny, w_deny_nxt;
  logic              r_locked, w_locked_nxt;
  logic              w_otp_edge, w_user_edge, w_match;
  logic [c_FW:0]     w_fail_inc;

  assign w_otp_edge  = w_edge[0];
  assign w_user_edge = w_edge[1];
  assign w_match     = (r_user_q == r_otp_q);
  assign w_fail_inc  = {1'b0, r_fail_cnt} + 1'b1;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= ST_IDLE;
      r_otp_q    <= '0;
      r_user_q   <= '0;
      r_fail_cnt <= '0;
      r_timer    <= '0;
      r_armed    <= 1'b0;
      r_grant    <= 1'b0;
      r_deny     <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_otp_q    <= w_otp_nxt;
      r_user_q   <= w_user_nxt;
      r_fail_cnt <= w_fail_nxt;
      r_timer    <= w_timer_nxt;
      r_armed    <= w_armed_nxt;
      r_grant    <= w_grant_nxt;
      r_deny     <= w_deny_nxt;
      r_locked   <= w_locked_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_otp_nxt   = r_otp_q;
    w_user_nxt  = r_user_q;
    w_fail_nxt  = r_fail_cnt;
    w_timer_nxt = r_timer;

    case (r_state)
      ST_IDLE: begin
        if (w_otp_edge) begin
          w_otp_nxt   = otp_in;
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED, ST_DENY: begin
        // otp edge takes priority over a coincident user edge
        if (w_otp_edge) begin
          w_otp_nxt   = otp_in;
          w_state_nxt = ST_ARMED;
        end else if (w_user_edge) begin
          w_user_nxt  = user_in;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_match) begin
          w_fail_nxt  = '0;
          w_state_nxt = ST_GRANT;
        end else if (w_fail_inc == c_FAIL_LIMIT) begin
          w_fail_nxt  = c_MAX_FAIL;
          w_timer_nxt = c_LOCK_LOAD;
          w_state_nxt = ST_LOCK;
        end else begin
          w_fail_nxt  = w_fail_inc[c_FW-1:0];
          w_state_nxt = ST_DENY;
        end
      end
      ST_GRANT: begin
        if (w_otp_edge) begin
          w_otp_nxt   = otp_in;
          w_state_nxt = ST_ARMED;
        end
      end
      ST_LOCK: begin
        if (r_timer == '0) begin
          w_fail_nxt  = '0;
          w_otp_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decode the next state; CHECK keeps the previous status visible
  always_comb begin
    w_armed_nxt  = r_armed;
    w_grant_nxt  = r_grant;
    w_deny_nxt   = r_deny;
    w_locked_nxt = r_locked;
    if (w_state_nxt != ST_CHECK) begin
      w_armed_nxt  = (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_DENY);
      w_grant_nxt  = (w_state_nxt == ST_GRANT);
      w_deny_nxt   = (w_state_nxt == ST_DENY);
      w_locked_nxt = (w_state_nxt == ST_LOCK);
    end
  end

  assign armed    = r_armed;
  assign grant    = r_grant;
  assign deny     = r_deny;
  assign locked   = r_locked;
  assign fail_cnt = r_fail_cnt;
  assign otp_q    = r_otp_q;

endmodule

`default_nettype wire

// File: tb/tb_otp_auth_ctrl.sv
// Directed and randomized bench for otp_auth_ctrl against a flag-level model of
// the authentication rules.
`default_nettype none

module tb_otp_auth_ctrl;

  localparam int CODE_W      = 4;
  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYCLES = 1024;
  localparam int SYNC_STAGES = 2;
  localparam int DB_CYCLES   = 16;
  localparam int FW          = $clog2(MAX_FAIL + 1);
`ifdef OTP_DEBOUNCE_EN
  localparam int c_FILT = DB_CYCLES;
`else
  localparam int c_FILT = 0;
`endif
  // Raw rise to first registered status change
  localparam int c_LAT    = SYNC_STAGES + 2 + c_FILT;
  localparam int c_HOLD   = c_FILT + 2;
  localparam int c_SETTLE = c_LAT + 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [CODE_W-1:0] otp_in = '0;
  logic [CODE_W-1:0] user_in = '0;
  logic              otp_latch = 1'b0;
  logic              user_latch = 1'b0;
  logic              armed, grant, deny, locked;
  logic [FW-1:0]     fail_cnt;
  logic [CODE_W-1:0] otp_q;

  always #5 clk = ~clk;

  otp_auth_ctrl #(
    .CODE_W(CODE_W), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES),
    .SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .otp_in(otp_in), .user_in(user_in),
    .otp_latch(otp_latch), .user_latch(user_latch), .armed(armed),
    .grant(grant), .deny(deny), .locked(locked), .fail_cnt(fail_cnt), .otp_q(otp_q)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [CODE_W-1:0] m_otp;
  int                m_fail;
  bit                m_armed, m_grant, m_deny, m_locked;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".armed"},  32'(armed),    32'(m_armed));
    chk({tag, ".grant"},  32'(grant),    32'(m_grant));
    chk({tag, ".deny"},   32'(deny),     32'(m_deny));
    chk({tag, ".locked"}, 32'(locked),   32'(m_locked));
    chk({tag, ".fail"},   32'(fail_cnt), 32'(m_fail));
    chk({tag, ".otp_q"},  32'(otp_q),    32'(m_otp));
  endtask

  task automatic m_reset();
    m_otp = '0; m_fail = 0;
    m_armed = 0; m_grant = 0; m_deny = 0; m_locked = 0;
  endtask

  task automatic m_otp_edge(input logic [CODE_W-1:0] c);
    if (!m_locked) begin
      m_otp = c; m_armed = 1; m_grant = 0; m_deny = 0;
    end
  endtask

  task automatic m_user_edge(input logic [CODE_W-1:0] c);
    if (!m_locked && m_armed) begin
      if (c == m_otp) begin
        m_grant = 1; m_deny = 0; m_armed = 0; m_fail = 0;
      end else begin
        m_fail++;
        if (m_fail >= MAX_FAIL) begin
          m_fail = MAX_FAIL; m_locked = 1; m_armed = 0; m_deny = 0; m_grant = 0;
        end else begin
          m_deny = 1; m_armed = 1; m_grant = 0;
        end
      end
    end
  endtask

  task automatic m_unlock();
    m_locked = 0; m_fail = 0; m_otp = '0; m_armed = 0; m_grant = 0; m_deny = 0;
  endtask

  task automatic press(input bit do_otp, input bit do_user, input logic [CODE_W-1:0] oc,
                       input logic [CODE_W-1:0] uc, input int extra);
    otp_in = oc; user_in = uc;
    otp_latch = do_otp; user_latch = do_user;
    step(c_HOLD + extra);
    otp_latch = 1'b0; user_latch = 1'b0;
    step(c_SETTLE);
    if (do_otp) m_otp_edge(oc);
    else if (do_user) m_user_edge(uc);
  endtask

  task automatic wait_unlock();
    int k = 0;
    while (locked === 1'b1 && k < LOCK_CYCLES + 100) begin
      step(1);
      k++;
    end
    chk("unlock_bound", 32'(locked), 32'd0);
    m_unlock();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".armed"},  32'(armed),    32'd0);
    chk({tag, ".grant"},  32'(grant),    32'd0);
    chk({tag, ".deny"},   32'(deny),     32'd0);
    chk({tag, ".locked"}, 32'(locked),   32'd0);
    chk({tag, ".fail"},   32'(fail_cnt), 32'd0);
    chk({tag, ".otp_q"},  32'(otp_q),    32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CODE_W-1:0] oc, uc;
    int op;

    m_reset();
    #2 reset = 1'b0;
    step(3);
    check_all_zero("reset");
    reset = 1'b1;
    step(5);
    check_model("post_reset");

    // Exact capture latency, then match
    otp_in = 4'hA; otp_latch = 1'b1;
    step(c_LAT - 1);
    chk("lat_before", 32'(armed), 32'd0);
    step(1);
    chk("lat_at", 32'(armed), 32'd1);
    chk("lat_otp_q", 32'(otp_q), 32'hA);
    otp_latch = 1'b0;
    step(c_SETTLE);
    m_otp_edge(4'hA);
    check_model("t1_armed");
    press(0, 1, 4'hA, 4'hA, 0);
    check_model("t1_grant");
    chk("t1_grant_const", 32'(grant), 32'd1);

    // Mismatch then retry against the same OTP
    press(1, 0, 4'h5, 4'h0, 0);
    press(0, 1, 4'h5, 4'h6, 0);
    check_model("t2_deny");
    chk("t2_fail_const", 32'(fail_cnt), 32'd1);
    press(0, 1, 4'h5, 4'h5, 1);
    check_model("t2_grant");

    // Lockout with exact duration; otp button held across the exit must not fire
    press(1, 0, 4'h3, 4'h0, 0);
    press(0, 1, 4'h3, 4'h0, 0);
    press(0, 1, 4'h3, 4'h1, 2);
    check_model("t3_fail2");
    user_in = 4'h2; user_latch = 1'b1;
    step(c_LAT);
    chk("t3_check_not_locked", 32'(locked), 32'd0);
    step(1);
    m_user_edge(4'h2);
    check_model("t3_locked");
    chk("t3_fail_sat", 32'(fail_cnt), 32'(MAX_FAIL));
    otp_in = 4'h9; otp_latch = 1'b1;
    step(LOCK_CYCLES - 1);
    chk("t3_still_locked", 32'(locked), 32'd1);
    chk("t3_otp_kept", 32'(otp_q), 32'h3);
    step(1);
    m_unlock();
    check_model("t3_exit");
    step(c_LAT + 5);
    check_model("t3_no_fire");
    otp_latch = 1'b0; user_latch = 1'b0;
    step(c_SETTLE);

    // Coincident edges while armed: otp wins
    press(1, 0, 4'h1, 4'h0, 0);
    press(1, 1, 4'h7, 4'h1, 0);
    check_model("t4_both");

    // Held button: single capture even though otp_in changes
    otp_in = 4'h2; otp_latch = 1'b1;
    step(20);
    otp_in = 4'h9;
    step(80);
    otp_latch = 1'b0;
    step(c_SETTLE);
    m_otp_edge(4'h2);
    check_model("t5_hold");

`ifdef OTP_DEBOUNCE_EN
    otp_in = 4'hC; otp_latch = 1'b1;
    step(5);
    otp_latch = 1'b0;
    step(c_SETTLE);
    check_model("t5_glitch");
`endif

    // Asynchronous reset while in CHECK
    user_in = 4'h4; user_latch = 1'b1;
    step(c_LAT);
    chk("t6_check_armed", 32'(armed), 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("t6_rst_check");
    user_latch = 1'b0;
    step(3);
    reset = 1'b1;
    step(5);
    m_reset();
    press(0, 1, 4'h0, 4'h0, 0);
    check_model("t6_idle_user_ignored");

    // Asynchronous reset while in LOCK
    press(1, 0, 4'h8, 4'h0, 0);
    press(0, 1, 4'h8, 4'h1, 0);
    press(0, 1, 4'h8, 4'h2, 0);
    press(0, 1, 4'h8, 4'h3, 0);
    check_model("t6_locked");
    step(100);
    reset = 1'b0;
    #1;
    check_all_zero("t6_rst_lock");
    step(3);
    reset = 1'b1;
    step(5);
    m_reset();
    check_model("t6_after_rst");

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 3));
      oc = CODE_W'($urandom);
      uc = ($urandom_range(0, 1) == 1) ? m_otp : CODE_W'($urandom);
      case (op)
        0:       press(1, 0, oc, uc, int'($urandom_range(0, 3)));
        3:       press(1, 1, oc, uc, int'($urandom_range(0, 3)));
        default: press(0, 1, oc, uc, int'($urandom_range(0, 3)));
      endcase
      check_model($sformatf("rnd%0d", i));
      if (m_locked) begin
        for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
          press(1, 1, CODE_W'($urandom), CODE_W'($urandom), 0);
          check_model($sformatf("rnd%0d_lockpress%0d", i, j));
        end
        wait_unlock();
        check_model($sformatf("rnd%0d_unlock", i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
